// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch front end feeding the IF/ID pipeline register. Owns the
//   fetch PC, keeps at most one instruction-memory request in flight, buffers
//   the returned word and presents a PC/instruction pair (or a NOP bubble).
//   Redirects abandon sequential fetch and discard any in-flight response.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   stall                   IF/ID holding; buffered instruction not consumed
//   redirect, redirect_pc   branch/jump redirect and its target (bits [1:0] ignored)
//   imem_req/ready/addr     request handshake to instruction memory
//   imem_rvalid/rdata       in-order response from instruction memory
//   pc_out, instr_out       buffered PC/instruction (0 / NOP_INSTR when invalid)
//   instr_valid             buffer holds a real instruction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc_buf_q, pc_buf_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic        buf_valid_q, buf_valid_d;

  logic        accept;
  logic [31:0] redirect_tgt;

  // A new request only goes out when the buffer is free or drains this cycle,
  // which is what guarantees a response never lands on an unconsumed word.
  always_comb begin
    imem_req = (state_q == S_ISSUE) && !redirect && (!buf_valid_q || !stall);
  end

  assign accept       = imem_req && imem_ready;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    pc_buf_d    = pc_buf_q;
    instr_buf_d = instr_buf_q;
    buf_valid_d = buf_valid_q;

    // The payload registers are returned to bubble values when the buffer
    // empties so the outputs can come straight from flops.
    if (buf_valid_q && !stall) begin
      buf_valid_d = 1'b0;
      pc_buf_d    = '0;
      instr_buf_d = NOP_INSTR;
    end

    case (state_q)
      S_IDLE: state_d = S_ISSUE;
      S_ISSUE: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_ISSUE;
          if (!redirect) begin
            instr_buf_d = imem_rdata;
            pc_buf_d    = req_pc_q;
            buf_valid_d = 1'b1;
          end
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides pc and flushes the buffer, including over stall.
    if (redirect && (state_q != S_IDLE)) begin
      pc_d        = redirect_tgt;
      buf_valid_d = 1'b0;
      pc_buf_d    = '0;
      instr_buf_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      pc_buf_q    <= '0;
      instr_buf_q <= NOP_INSTR;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      pc_buf_q    <= pc_buf_d;
      instr_buf_q <= instr_buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_buf_q;
  assign instr_out   = instr_buf_q;
  assign instr_valid = buf_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit
//   Randomized bench for if_fetch_unit. A memory model answers requests with
//   rdata = addr ^ 0xA5A5_0000 after 1..lat_max cycles. The expected stream of
//   delivered PCs is generated from the architectural rule: sequential +4 from
//   RESET_PC, restarting at (target & ~3) on every redirect. A monitor compares
//   each buffered instruction against the queue front.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] XOR_KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  int          since_rst;
  bit          outstanding;
  int          cnt;
  logic [31:0] resp_addr;
  bit          acc_s;
  logic [31:0] addr_s;
  int          lat_max, p_stall, p_redir, p_ready;
  int          valid_seen;
  int          force_stall;
  bit          force_redir;
  logic [31:0] force_tgt;
  int          resets_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b0;
    #1;
    check("rst_req",   {31'b0, imem_req},    32'd0);
    check("rst_addr",  imem_addr,            RESET_PC);
    check("rst_pc",    pc_out,               32'd0);
    check("rst_instr", instr_out,            NOP_INSTR);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    repeat (n) @(posedge clk);
    #2;
    rst_n       = 1'b1;
    outstanding = 1'b0;
    acc_s       = 1'b0;
    since_rst   = 0;
    exp_q.delete();
    gen_pc      = RESET_PC;
    refill();
  endtask

  // One clock cycle: observe at the falling edge, then drive after the rising edge.
  task automatic step();
    logic [31:0] tgt;
    @(negedge clk);
    acc_s = 1'b0;
    if (rst_n) begin
      if (since_rst == 0) check("idle_req", {31'b0, imem_req}, 32'd0);
      if (since_rst == 1) begin
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
      end
      if (redirect || (instr_valid && stall) || outstanding)
        check("req_blocked", {31'b0, imem_req}, 32'd0);
      if (!instr_valid) begin
        check("bubble_pc",    pc_out,    32'd0);
        check("bubble_instr", instr_out, NOP_INSTR);
      end else begin
        valid_seen++;
        if (!redirect) begin
          check("pc_out",    pc_out,    exp_q[0]);
          check("instr_out", instr_out, exp_q[0] ^ XOR_KEY);
          if (!stall) begin
            void'(exp_q.pop_front());
            refill();
          end
        end
      end
      acc_s  = imem_req && imem_ready;
      addr_s = imem_addr;
    end
    @(posedge clk);
    #2;
    since_rst++;
    // memory model
    if (outstanding && imem_rvalid) outstanding = 1'b0;
    if (acc_s) begin
      outstanding = 1'b1;
      cnt         = $urandom_range(lat_max, 1);
      resp_addr   = addr_s;
    end else if (outstanding) begin
      cnt--;
    end
    imem_rvalid = outstanding && (cnt == 1);
    imem_rdata  = imem_rvalid ? (resp_addr ^ XOR_KEY) : $urandom;
    imem_ready  = ($urandom_range(99, 0) < p_ready);
    // control stimulus
    if (force_stall > 0) begin
      stall = 1'b1;
      force_stall--;
    end else begin
      stall = ($urandom_range(99, 0) < p_stall);
    end
    redirect    = 1'b0;
    redirect_pc = $urandom;
    if (since_rst >= 2) begin
      if (force_redir) begin
        redirect    = 1'b1;
        redirect_pc = force_tgt;
        force_redir = 1'b0;
      end else if ($urandom_range(99, 0) < p_redir) begin
        tgt = $urandom;
        case ($urandom_range(3, 0))
          0:       tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000B);
          1:       tgt = tgt & 32'h0000_0FFF;
          default: tgt = tgt & 32'h0000_FFFF;
        endcase
        redirect    = 1'b1;
        redirect_pc = tgt;
      end
    end
    if (redirect) begin
      exp_q.delete();
      gen_pc = redirect_pc & ~32'd3;
      refill();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    force_stall = 0;
    force_redir = 1'b0;
    force_tgt   = '0;
    valid_seen  = 0;
    resets_left = 6;
    lat_max = 1; p_stall = 0; p_redir = 0; p_ready = 100;
    @(posedge clk);
    #2;
    do_reset(3);

    // Streaming with a 1-cycle memory: one instruction every two cycles.
    repeat (10) step();
    valid_seen = 0;
    repeat (20) step();
    check("stream_rate", valid_seen, 32'd10);

    // Held stall, then misaligned redirect, then redirect near the wrap point.
    force_stall = 3;
    repeat (8) step();
    force_redir = 1'b1; force_tgt = 32'h0000_0103;
    repeat (10) step();
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
    repeat (12) step();

    // Redirects against a slower memory.
    lat_max = 3;
    force_redir = 1'b1; force_tgt = 32'h0000_0100;
    repeat (20) step();

    // Randomized traffic with occasional mid-flight resets.
    p_ready = 70; p_stall = 25; p_redir = 5;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (outstanding && resets_left > 0 && $urandom_range(199, 0) == 0) begin
        resets_left--;
        do_reset(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC and issues one instruction-memory request at a time, tolerating any memory latency of one cycle or more. It buffers the returned word and presents a PC/instruction pair (or a NOP bubble) to IF/ID. It honours hazard stalls and discards in-flight fetches when a branch or jump redirect arrives.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, word presented when no valid instruction is buffered
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  IF/ID is holding this cycle; a buffered instruction is not consumed
- redirect  in  1  branch taken or jump resolved; abandon sequential fetch
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0
- imem_req  out  1  request valid
- imem_ready  in  1  request accepted when imem_req && imem_ready
- imem_addr  out  32  request address, always equal to the internal pc
- imem_rvalid  in  1  response valid; in order, at least 1 cycle after acceptance
- imem_rdata  in  32  response word
- pc_out  out  32  PC of the buffered instruction to IF/ID, 0 when invalid
- instr_out  out  32  buffered instruction to IF/ID, NOP_INSTR when invalid
- instr_valid  out  1  buffer holds a real instruction

## Operation
- Registers:
  - pc: next address to request.
  - req_pc: address of the outstanding request.
  - Buffer: instr_buf, pc_buf, buf_valid.
  - state.
- States:
  - IDLE: reset state.
  - ISSUE: may request.
  - WAIT: one live request outstanding.
  - DISCARD: one stale request outstanding.
- IDLE: imem_req=0; always moves to ISSUE on the next edge.
- ISSUE:
  - imem_req = !redirect && (!buf_valid || !stall).
  - On acceptance: req_pc<=pc, pc<=pc+4, go to WAIT.
- WAIT:
  - On rvalid: instr_buf<=rdata, pc_buf<=req_pc, buf_valid<=1, go to ISSUE.
- DISCARD:
  - On rvalid: drop rdata, go to ISSUE.
- imem_rvalid is ignored in IDLE and ISSUE.
- Buffer consume: buf_valid && !stall clears buf_valid at the edge, unless a response loads it in the same cycle.
- Redirect has the highest priority, in any state except IDLE:
  - pc<=redirect_pc & ~3 and buf_valid<=0.
  - ISSUE: stays ISSUE; no request is issued that cycle.
  - WAIT without rvalid: goes to DISCARD.
  - WAIT with rvalid in the same cycle: response dropped, goes to ISSUE.
  - DISCARD: stays DISCARD (the stale response is still owed).
- Redirect with stall in the same cycle: redirect wins; buffer cleared.
- pc arithmetic is 32-bit and wraps modulo 2^32: 0xFFFF_FFFC+4 = 0.
- At most one request is outstanding. A response therefore never arrives while the buffer is valid and unconsumed.

## Timing
- Reset values (rst_n low, asynchronous):
  - state=IDLE, pc=RESET_PC, req_pc=0, buf_valid=0.
  - imem_req=0, imem_addr=RESET_PC.
  - pc_out=0, instr_out=NOP_INSTR, instr_valid=0.
- Reset asserted mid-operation aborts the outstanding request immediately. The memory is reset alongside and must not return it.
- First request: the second rising edge after rst_n deasserts (IDLE, then ISSUE).
- Latency with a 1-cycle memory:
  - Request accepted at cycle t.
  - rvalid arrives at t+1.
  - instr_valid is seen at t+2; the next request is also issued at t+2.
  - Peak throughput: one instruction per 2 cycles.
- Outputs pc_out, instr_out and instr_valid come straight from registers. imem_req is combinational from state, buf_valid, stall and redirect.

## Test plan
- Reset: hold rst_n low 3 cycles -> imem_req=0, instr_out=0x13, pc_out=0. Release -> imem_req=1 with imem_addr=0 on the 2nd edge.
- Streaming: memory with 1-cycle latency and rdata=addr^0xA5A5_0000 -> pc_out 0,4,8,... each with instr_valid for one cycle, valid every 2 cycles.
- Stall: assert stall for 3 cycles while pc 0x4 is buffered -> instr_out is held stable, imem_req=0. Drop stall -> next request at 0x8.
- Redirect in WAIT with 3-cycle latency: redirect_pc=0x100 one cycle after acceptance -> stale word never appears on instr_out; next request at 0x100, then pc_out=0x100.
- Simultaneous events:
  - Redirect together with rvalid in WAIT -> response dropped; next imem_addr=0x200.
  - Redirect together with stall while the buffer is valid -> instr_valid=0 on the next cycle.
- Misaligned redirect_pc=0x103 -> imem_addr=0x100. Separately, pulse rst_n low while in WAIT -> all outputs at reset values immediately.
